// File: rtl/mips_pkg.sv
// Shared MIPS pipeline definitions: next-PC select encodings, bubble instruction, reset vector.
package mips_pkg;

    typedef enum logic [1:0] {
        PCSRC_SEQ = 2'b00,
        PCSRC_BR  = 2'b01,
        PCSRC_J   = 2'b10,
        PCSRC_JR  = 2'b11
    } pc_src_e;

    localparam logic [31:0] NOP_INSTR            = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

endpackage

// File: rtl/adder.sv
// Generic parameterised adder shared across the datapath.
module ADDER #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] A,
    input  logic [WIDTH-1:0] B,
    output logic [WIDTH-1:0] SUM
);

    assign SUM = A + B;

endmodule

// File: rtl/if_fetch_stage.sv
// Instruction-fetch stage: program counter, next-PC select and the IF/ID pipeline register.
module if_fetch_stage
    import mips_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = 32,
    parameter int                    INSTR_WIDTH  = 32,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(DEFAULT_RESET_VECTOR)
) (
    input  logic                   CLK,
    input  logic                   RST,
    input  logic                   STALL,
    input  logic                   FLUSH,
    input  logic [1:0]             PC_SRC,
    input  logic [ADDR_WIDTH-1:0]  BRANCH_TARGET,
    input  logic [25:0]            JUMP_INDEX,
    input  logic [ADDR_WIDTH-1:0]  JR_TARGET,
    output logic [ADDR_WIDTH-1:0]  IMEM_ADDR,
    input  logic [INSTR_WIDTH-1:0] IMEM_RDATA,
    output logic [INSTR_WIDTH-1:0] IF_ID_INSTR,
    output logic [ADDR_WIDTH-1:0]  IF_ID_PC_PLUS4,
    output logic                   IF_ID_VALID,
    output logic                   ALIGN_ERR
);

    localparam logic [ADDR_WIDTH-1:0]  PC_STEP = ADDR_WIDTH'(4);
    localparam logic [INSTR_WIDTH-1:0] BUBBLE  = INSTR_WIDTH'(NOP_INSTR);

    logic [ADDR_WIDTH-1:0]  pc_q, pc_d;
    logic [ADDR_WIDTH-1:0]  pc_plus4;
    logic [ADDR_WIDTH-1:0]  jump_target;
    logic                   align_err_q, align_err_d;
    logic [INSTR_WIDTH-1:0] if_id_instr_q, if_id_instr_d;
    logic [ADDR_WIDTH-1:0]  if_id_pc4_q, if_id_pc4_d;
    logic                   if_id_valid_q, if_id_valid_d;

    ADDER #(.WIDTH(ADDR_WIDTH)) u_pc_adder (
        .A   (pc_q),
        .B   (PC_STEP),
        .SUM (pc_plus4)
    );

    // Region bits come from the jump's own PC+4, which sits in IF/ID while it decodes.
    assign jump_target = {if_id_pc4_q[ADDR_WIDTH-1:28], JUMP_INDEX, 2'b00};

    always_comb begin
        pc_d        = pc_q;
        align_err_d = align_err_q;
        case (PC_SRC)
            PCSRC_BR: begin
                pc_d = {BRANCH_TARGET[ADDR_WIDTH-1:2], 2'b00};
                if (|BRANCH_TARGET[1:0]) align_err_d = 1'b1;
            end
            PCSRC_J:  pc_d = jump_target;
            PCSRC_JR: begin
                pc_d = {JR_TARGET[ADDR_WIDTH-1:2], 2'b00};
                if (|JR_TARGET[1:0]) align_err_d = 1'b1;
            end
            default:  if (!STALL) pc_d = pc_plus4;
        endcase
    end

    always_comb begin
        if_id_instr_d = if_id_instr_q;
        if_id_pc4_d   = if_id_pc4_q;
        if_id_valid_d = if_id_valid_q;
        if (FLUSH) begin
            if_id_instr_d = BUBBLE;
            if_id_pc4_d   = '0;
            if_id_valid_d = 1'b0;
        end else if (!STALL) begin
            if_id_instr_d = IMEM_RDATA;
            if_id_pc4_d   = pc_plus4;
            if_id_valid_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            pc_q          <= RESET_VECTOR;
            align_err_q   <= 1'b0;
            if_id_instr_q <= BUBBLE;
            if_id_pc4_q   <= '0;
            if_id_valid_q <= 1'b0;
        end else begin
            pc_q          <= pc_d;
            align_err_q   <= align_err_d;
            if_id_instr_q <= if_id_instr_d;
            if_id_pc4_q   <= if_id_pc4_d;
            if_id_valid_q <= if_id_valid_d;
        end
    end

    assign IMEM_ADDR      = pc_q;
    assign IF_ID_INSTR    = if_id_instr_q;
    assign IF_ID_PC_PLUS4 = if_id_pc4_q;
    assign IF_ID_VALID    = if_id_valid_q;
    assign ALIGN_ERR      = align_err_q;

endmodule

// File: tb/tb_if_fetch_stage.sv
// Bench for if_fetch_stage: directed literal sequence, then random hazards against a behavioural model.
module tb_if_fetch_stage;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        STALL = 1'b0;
    logic        FLUSH = 1'b0;
    logic [1:0]  PC_SRC = 2'b00;
    logic [31:0] BRANCH_TARGET = 32'h0;
    logic [25:0] JUMP_INDEX = 26'h0;
    logic [31:0] JR_TARGET = 32'h0;
    logic [31:0] IMEM_ADDR, IMEM_RDATA, IF_ID_INSTR, IF_ID_PC_PLUS4;
    logic        IF_ID_VALID, ALIGN_ERR;

    // second instance: reset vector at the top of memory, free-running
    logic        z1 = 1'b0;
    logic [1:0]  z2 = 2'b00;
    logic [25:0] z26 = 26'h0;
    logic [31:0] z32 = 32'h0;
    logic [31:0] w_addr, w_instr, w_pc4;
    logic        w_valid, w_aerr;

    int checks = 0;
    int errors = 0;
    bit chk_en = 1'b0;

    function automatic logic [31:0] mem(input logic [31:0] a);
        return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
    endfunction

    assign IMEM_RDATA = mem(IMEM_ADDR);

    always #5 CLK = ~CLK;

    if_fetch_stage dut (
        .CLK(CLK), .RST(RST), .STALL(STALL), .FLUSH(FLUSH), .PC_SRC(PC_SRC),
        .BRANCH_TARGET(BRANCH_TARGET), .JUMP_INDEX(JUMP_INDEX), .JR_TARGET(JR_TARGET),
        .IMEM_ADDR(IMEM_ADDR), .IMEM_RDATA(IMEM_RDATA), .IF_ID_INSTR(IF_ID_INSTR),
        .IF_ID_PC_PLUS4(IF_ID_PC_PLUS4), .IF_ID_VALID(IF_ID_VALID), .ALIGN_ERR(ALIGN_ERR)
    );

    if_fetch_stage #(.RESET_VECTOR(32'hFFFF_FFFC)) dut_wrap (
        .CLK(CLK), .RST(RST), .STALL(z1), .FLUSH(z1), .PC_SRC(z2),
        .BRANCH_TARGET(z32), .JUMP_INDEX(z26), .JR_TARGET(z32),
        .IMEM_ADDR(w_addr), .IMEM_RDATA(z32), .IF_ID_INSTR(w_instr),
        .IF_ID_PC_PLUS4(w_pc4), .IF_ID_VALID(w_valid), .ALIGN_ERR(w_aerr)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, exp);
        end
    endtask

    // Behavioural model: architectural state updated from the priority rules.
    logic [31:0] m_pc = 32'h0, m_instr = 32'h0, m_pc4 = 32'h0;
    logic        m_valid = 1'b0, m_aerr = 1'b0;

    always @(posedge CLK or negedge RST) begin : model
        logic [31:0] npc;
        logic        bad;
        if (!RST) begin
            m_pc <= 32'h0; m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0; m_aerr <= 1'b0;
        end else begin
            bad = 1'b0;
            case (PC_SRC)
                2'd1: begin npc = BRANCH_TARGET & ~32'd3; bad = (BRANCH_TARGET % 4) != 0; end
                2'd2: npc = (m_pc4 & 32'hF000_0000) | ({6'b0, JUMP_INDEX} << 2);
                2'd3: begin npc = JR_TARGET & ~32'd3; bad = (JR_TARGET % 4) != 0; end
                default: npc = STALL ? m_pc : m_pc + 32'd4;
            endcase
            if (FLUSH) begin
                m_instr <= 32'h0; m_pc4 <= 32'h0; m_valid <= 1'b0;
            end else if (!STALL) begin
                m_instr <= mem(m_pc); m_pc4 <= m_pc + 32'd4; m_valid <= 1'b1;
            end
            m_pc   <= npc;
            m_aerr <= m_aerr | bad;
        end
    end

    always @(negedge CLK) begin
        if (chk_en) begin
            check("model_addr",  IMEM_ADDR, m_pc);
            check("model_instr", IF_ID_INSTR, m_instr);
            check("model_pc4",   IF_ID_PC_PLUS4, m_pc4);
            check("model_valid", 32'(IF_ID_VALID), 32'(m_valid));
            check("model_aerr",  32'(ALIGN_ERR), 32'(m_aerr));
        end
    end

    task automatic drive(input logic st, input logic fl, input logic [1:0] src,
                         input logic [31:0] bt, input logic [25:0] ji, input logic [31:0] jr);
        STALL = st; FLUSH = fl; PC_SRC = src;
        BRANCH_TARGET = bt; JUMP_INDEX = ji; JR_TARGET = jr;
    endtask

    task automatic idle();
        drive(1'b0, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
    endtask

    task automatic rand_cycles(input int n);
        for (int i = 0; i < n; i++) begin
            logic [1:0] src;
            @(negedge CLK);
            src = ($urandom % 4 == 0) ? 2'($urandom % 4) : 2'b00;
            drive(($urandom % 4) == 0,
                  (src != 2'b00) || (($urandom % 8) == 0),
                  src,
                  ($urandom & ~32'd3) | ((($urandom % 8) == 0) ? 32'($urandom % 4) : 32'd0),
                  26'($urandom),
                  ($urandom & ~32'd3) | ((($urandom % 8) == 0) ? 32'($urandom % 4) : 32'd0));
        end
    endtask

    initial begin
        #1 RST = 1'b0;
        #1 chk_en = 1'b1;
        check("rst_addr",  IMEM_ADDR, 32'h0);
        check("rst_valid", 32'(IF_ID_VALID), 32'h0);
        check("rst_instr", IF_ID_INSTR, 32'h0);
        check("rst_aerr",  32'(ALIGN_ERR), 32'h0);
        check("wrap_rst",  w_addr, 32'hFFFF_FFFC);

        @(negedge CLK); RST = 1'b1;
        check("n0_addr", IMEM_ADDR, 32'h0);
        check("n0_valid", 32'(IF_ID_VALID), 32'h0);
        @(negedge CLK);
        check("n1_addr", IMEM_ADDR, 32'h4);
        check("n1_pc4", IF_ID_PC_PLUS4, 32'h4);
        check("n1_valid", 32'(IF_ID_VALID), 32'h1);
        check("wrap_pc", w_addr, 32'h0);
        @(negedge CLK);
        check("n2_addr", IMEM_ADDR, 32'h8);
        check("n2_pc4", IF_ID_PC_PLUS4, 32'h8);
        @(negedge CLK);
        check("n3_addr", IMEM_ADDR, 32'hC);
        check("n3_pc4", IF_ID_PC_PLUS4, 32'hC);
        @(negedge CLK);
        check("n4_addr", IMEM_ADDR, 32'h10);
        drive(1'b0, 1'b1, 2'b01, 32'h40, 26'h0, 32'h0);
        @(negedge CLK);
        check("br_addr", IMEM_ADDR, 32'h40);
        check("br_valid", 32'(IF_ID_VALID), 32'h0);
        idle();
        @(negedge CLK);
        check("br_next_addr", IMEM_ADDR, 32'h44);
        check("br_next_instr", IF_ID_INSTR, mem(32'h40));
        check("br_next_valid", 32'(IF_ID_VALID), 32'h1);
        drive(1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 32'h9000_0000);
        @(negedge CLK);
        check("jr_hi_addr", IMEM_ADDR, 32'h9000_0000);
        idle();
        @(negedge CLK);
        check("j_pc4", IF_ID_PC_PLUS4, 32'h9000_0004);
        drive(1'b0, 1'b1, 2'b10, 32'h0, 26'h0000100, 32'h0);
        @(negedge CLK);
        check("j_addr", IMEM_ADDR, 32'h9000_0400);
        drive(1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 32'h1C);
        @(negedge CLK);
        idle();
        @(negedge CLK);
        check("pre_stall_addr", IMEM_ADDR, 32'h20);
        drive(1'b1, 1'b0, 2'b00, 32'h0, 26'h0, 32'h0);
        for (int i = 0; i < 3; i++) begin
            @(negedge CLK);
            check("stall_addr", IMEM_ADDR, 32'h20);
            check("stall_pc4", IF_ID_PC_PLUS4, 32'h20);
            check("stall_instr", IF_ID_INSTR, mem(32'h1C));
            check("stall_valid", 32'(IF_ID_VALID), 32'h1);
        end
        idle();
        @(negedge CLK);
        check("unstall_addr", IMEM_ADDR, 32'h24);
        drive(1'b1, 1'b1, 2'b00, 32'h0, 26'h0, 32'h0);
        @(negedge CLK);
        check("sf_addr", IMEM_ADDR, 32'h24);
        check("sf_instr", IF_ID_INSTR, 32'h0);
        check("sf_valid", 32'(IF_ID_VALID), 32'h0);
        drive(1'b0, 1'b1, 2'b11, 32'h0, 26'h0, 32'h0000_0102);
        @(negedge CLK);
        check("mis_addr", IMEM_ADDR, 32'h100);
        check("mis_aerr", 32'(ALIGN_ERR), 32'h1);
        idle();
        @(negedge CLK);
        check("mis_sticky", 32'(ALIGN_ERR), 32'h1);

        rand_cycles(3000);

        @(negedge CLK);
        idle();
        #2 RST = 1'b0;
        #1;
        check("arst_addr",  IMEM_ADDR, 32'h0);
        check("arst_instr", IF_ID_INSTR, 32'h0);
        check("arst_pc4",   IF_ID_PC_PLUS4, 32'h0);
        check("arst_valid", 32'(IF_ID_VALID), 32'h0);
        check("arst_aerr",  32'(ALIGN_ERR), 32'h0);
        @(negedge CLK); RST = 1'b1;

        rand_cycles(1000);
        @(negedge CLK);
        idle();
        @(negedge CLK);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_stage.md
Name: if_fetch_stage

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline: owns the program counter, selects next PC and drives the instruction-memory address.
- Registers the fetched instruction and PC+4 into the IF/ID pipeline register consumed by decode.
- Honours hazard-unit stall and flush; accepts branch, jump and jump-register redirects resolved in ID.

Parameters:
- ADDR_WIDTH, 32, PC / instruction-address width.
- INSTR_WIDTH, 32, instruction word width.
- RESET_VECTOR, 32'h0000_0000, PC value after reset; must be word-aligned.

Ports:
- CLK  in  1  pipeline clock, rising-edge.
- RST  in  1  asynchronous reset, active-low.
- STALL  in  1  hold PC and IF/ID contents.
- FLUSH  in  1  replace IF/ID contents with a bubble.
- PC_SRC  in  2  next-PC select: 00 sequential, 01 branch, 10 jump, 11 jump-register.
- BRANCH_TARGET  in  ADDR_WIDTH  branch target computed in ID.
- JUMP_INDEX  in  26  instr[25:0] of the J/JAL in ID.
- JR_TARGET  in  ADDR_WIDTH  rs value for JR/JALR.
- IMEM_ADDR  out  ADDR_WIDTH  instruction-memory address, equal to current PC.
- IMEM_RDATA  in  INSTR_WIDTH  instruction word; combinational read of IMEM_ADDR.
- IF_ID_INSTR  out  INSTR_WIDTH  registered instruction.
- IF_ID_PC_PLUS4  out  ADDR_WIDTH  registered PC+4 of that instruction.
- IF_ID_VALID  out  1  IF/ID holds a real instruction.
- ALIGN_ERR  out  1  sticky flag: a redirect target had bits [1:0] != 0.

Behaviour:
- Reset (RST=0, asynchronous): PC=RESET_VECTOR, IF_ID_INSTR=0 (NOP), IF_ID_PC_PLUS4=0, IF_ID_VALID=0, ALIGN_ERR=0. The first fetch after release is at RESET_VECTOR.
- Reset asserted mid-operation overrides everything immediately; no partial state survives.
- IMEM_ADDR = PC, combinational from the PC register.
- PC_PLUS4 = PC + 4, modulo 2^ADDR_WIDTH; 0xFFFF_FFFC wraps to 0x0000_0000 with no flag.
- Jump target = {IF_ID_PC_PLUS4[31:28], JUMP_INDEX, 2'b00}. The upper bits come from the jump instruction's own PC+4, not the current PC.
- Next-PC priority on each rising edge:
  1. PC_SRC != 00: PC <= selected target. The redirect wins over STALL.
  2. STALL=1: PC holds.
  3. Otherwise: PC <= PC_PLUS4.
- Redirect targets (branch, JR) are loaded with bits [1:0] forced to 00. If the raw bits were nonzero, ALIGN_ERR <= 1 and stays set until reset.
- IF/ID priority on each rising edge:
  1. FLUSH=1: INSTR <= 0, PC_PLUS4 <= 0, VALID <= 0. FLUSH beats STALL.
  2. STALL=1: all three hold.
  3. Otherwise: INSTR <= IMEM_RDATA, PC_PLUS4 <= PC_PLUS4, VALID <= 1.
- The hazard unit asserts FLUSH together with any taken redirect. Latency is one cycle from redirect to fetch at the target.
- Simultaneous events:
  - STALL+FLUSH with PC_SRC=00: PC holds and IF/ID is bubbled.
  - STALL with PC_SRC!=00: PC loads the target; IF/ID follows the FLUSH/STALL rules.
- No internal FSM beyond the registers above. Throughput is one instruction per cycle when unstalled.

Decomposition:
- Shared package mips_pkg:
  - PC_SRC encodings PCSRC_SEQ=2'b00, PCSRC_BR=2'b01, PCSRC_J=2'b10, PCSRC_JR=2'b11.
  - NOP_INSTR=32'h0000_0000.
  - Default RESET_VECTOR.
- Sub-module: instantiate the existing parameterised ADDER for PC+4 (A=PC, B=4).
- The next-PC mux and the IF/ID register stay inline.

Test Plan:
- Reset then free-run 4 cycles, RESET_VECTOR=0 -> IMEM_ADDR sequence 0,4,8,C. IF_ID_PC_PLUS4 follows one cycle later (4,8,C). IF_ID_VALID=0 until the first edge after release, then 1.
- At PC=0x10: PC_SRC=01, BRANCH_TARGET=0x40, FLUSH=1 for one cycle -> next IMEM_ADDR=0x40, IF_ID_VALID=0 for that cycle, then fetches from 0x40 resume.
- IF_ID_PC_PLUS4=0x9000_0004 and PC_SRC=10, JUMP_INDEX=26'h0000100 -> PC=0x9000_0400.
- STALL=1 for 3 cycles at PC=0x20 -> IMEM_ADDR and IF/ID frozen; then STALL=0 -> PC=0x24.
- STALL=1 and FLUSH=1 together -> PC holds, IF_ID_INSTR=0, IF_ID_VALID=0.
- PC_SRC=11, JR_TARGET=0x0000_0102 -> PC=0x100, ALIGN_ERR=1 and stays set.
- PC preset to 0xFFFF_FFFC (RESET_VECTOR), one free-run edge -> PC=0x0000_0000.
- RST pulsed low mid-run -> all outputs return to reset values asynchronously, before the next clock edge.
